// File: rtl/pio_master.sv
// PIO initiator: turns one host request into a single-cycle PIO command and
// returns a response, failing reads that see no rd_vld within TIMEOUT_CYCLES.
module pio_master #(
  parameter int                ADDR_W         = 16,
  parameter int                DATA_W         = 32,
  parameter int                TIMEOUT_CYCLES = 16,
  parameter logic [DATA_W-1:0] ERR_DATA       = 32'hDEAD_BEEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_vld,
  output logic              req_rdy,
  input  logic              req_rw,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_vld,
  input  logic              rsp_rdy,
  output logic              rsp_rw,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              pio_cmd_vld,
  output logic              pio_rw,
  output logic [ADDR_W-1:0] pio_addr,
  output logic [DATA_W-1:0] pio_data_w,
  input  logic              pio_rd_vld,
  input  logic [DATA_W-1:0] pio_data_r,
  output logic              stray_rd
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RD, RESP} state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t              state, state_d;
  logic [7:0]          cnt, cnt_d;
  logic                req_rdy_d, rsp_vld_d, rsp_rw_d, rsp_err_d;
  logic [DATA_W-1:0]   rsp_data_d;
  logic                cmd_vld_d, pio_rw_d, stray_d;
  logic [ADDR_W-1:0]   pio_addr_d;
  logic [DATA_W-1:0]   pio_data_w_d;

  // Every output is a register; this block computes each one's next value.
  always_comb begin
    state_d      = state;
    cnt_d        = cnt;
    req_rdy_d    = req_rdy;
    rsp_vld_d    = rsp_vld;
    rsp_rw_d     = rsp_rw;
    rsp_data_d   = rsp_data;
    rsp_err_d    = rsp_err;
    cmd_vld_d    = 1'b0;
    pio_rw_d     = pio_rw;
    pio_addr_d   = pio_addr;
    pio_data_w_d = pio_data_w;
    stray_d      = stray_rd | (pio_rd_vld && state != WAIT_RD);

    case (state)
      IDLE: begin
        req_rdy_d = 1'b1;
        // req_rdy is low for one cycle after reset, so gate on it too
        if (req_vld && req_rdy) begin
          state_d      = ISSUE;
          req_rdy_d    = 1'b0;
          cmd_vld_d    = 1'b1;
          pio_rw_d     = req_rw;
          pio_addr_d   = req_addr;
          pio_data_w_d = req_wdata;
        end
      end
      ISSUE: begin
        if (pio_rw) begin
          state_d    = RESP;
          rsp_vld_d  = 1'b1;
          rsp_rw_d   = 1'b1;
          rsp_data_d = '0;
          rsp_err_d  = 1'b0;
        end else begin
          state_d = WAIT_RD;
          cnt_d   = '0;
        end
      end
      WAIT_RD: begin
        // data arriving in the final cycle still beats the timeout
        if (pio_rd_vld) begin
          state_d    = RESP;
          rsp_vld_d  = 1'b1;
          rsp_rw_d   = 1'b0;
          rsp_data_d = pio_data_r;
          rsp_err_d  = 1'b0;
        end else if (cnt == TO_LAST) begin
          state_d    = RESP;
          rsp_vld_d  = 1'b1;
          rsp_rw_d   = 1'b0;
          rsp_data_d = ERR_DATA;
          rsp_err_d  = 1'b1;
        end else begin
          cnt_d = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
        end
      end
      RESP: begin
        if (rsp_rdy) begin
          state_d   = IDLE;
          rsp_vld_d = 1'b0;
          req_rdy_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      req_rdy     <= 1'b0;
      rsp_vld     <= 1'b0;
      rsp_rw      <= 1'b0;
      rsp_data    <= '0;
      rsp_err     <= 1'b0;
      pio_cmd_vld <= 1'b0;
      pio_rw      <= 1'b0;
      pio_addr    <= '0;
      pio_data_w  <= '0;
      stray_rd    <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      req_rdy     <= req_rdy_d;
      rsp_vld     <= rsp_vld_d;
      rsp_rw      <= rsp_rw_d;
      rsp_data    <= rsp_data_d;
      rsp_err     <= rsp_err_d;
      pio_cmd_vld <= cmd_vld_d;
      pio_rw      <= pio_rw_d;
      pio_addr    <= pio_addr_d;
      pio_data_w  <= pio_data_w_d;
      stray_rd    <= stray_d;
    end
  end

endmodule

// File: doc/pio_master.md
Name: pio_master

Overview:
- PIO initiator: drives the PIO command bus (cmd_vld/rw/addr/data_w) that register/table blocks respond to, and collects their read data (rd_vld/data_r).
- Sits between a host-side request/response channel (CPU bridge or test sequencer) and one PIO responder.
- Issues one outstanding command at a time.
- Adds a read timeout so a missing rd_vld cannot hang the host.

Parameters:
- ADDR_W, 16, PIO address width; bit 15 selects table space in responders.
- DATA_W, 32, PIO data width.
- TIMEOUT_CYCLES, 16, maximum WAIT_RD cycles before a read is failed; legal range 2..255.
- ERR_DATA, 32'hDEAD_BEEF, rsp_data value returned on a timed-out read.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- req_vld  in  1  host request valid.
- req_rdy  out  1  block can accept a request.
- req_rw  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  request address.
- req_wdata  in  DATA_W  write data.
- rsp_vld  out  1  response valid.
- rsp_rdy  in  1  host accepts response.
- rsp_rw  out  1  echo of the request's rw.
- rsp_data  out  DATA_W  read data; 0 for writes; ERR_DATA on timeout.
- rsp_err  out  1  1 = read timed out.
- pio_cmd_vld  out  1  single-cycle command strobe.
- pio_rw  out  1  command direction.
- pio_addr  out  ADDR_W  command address.
- pio_data_w  out  DATA_W  command write data.
- pio_rd_vld  in  1  responder read-data valid.
- pio_data_r  in  DATA_W  responder read data.
- stray_rd  out  1  sticky flag: rd_vld seen when no read was pending.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- Reset values: state=IDLE, req_rdy=0 during the reset cycle and 1 afterwards, rsp_vld=0, rsp_err=0, rsp_rw=0, rsp_data=0, pio_cmd_vld=0, pio_rw=0, pio_addr=0, pio_data_w=0, stray_rd=0, timeout counter=0.
- All outputs are registered.
- Reset asserted in any state aborts the command in flight. No response is produced for it.

State machine (IDLE, ISSUE, WAIT_RD, RESP):
- IDLE:
  - req_rdy=1.
  - On req_vld, accepts the request at cycle T: latches rw/addr/wdata and goes to ISSUE.
- ISSUE (cycle T+1):
  - pio_cmd_vld=1 for exactly this one cycle, with pio_rw/pio_addr/pio_data_w = latched values.
  - Write: next state RESP; rsp_vld rises at T+2 with rsp_data=0 and rsp_err=0.
  - Read: next state WAIT_RD; timeout counter cleared.
- WAIT_RD:
  - pio_rd_vld=1 in any WAIT_RD cycle: capture pio_data_r, go to RESP with rsp_err=0.
  - With a one-cycle responder, rd_vld arrives at T+2 and rsp_vld rises at T+3.
  - Otherwise increment the counter.
  - If pio_rd_vld=0 in the cycle the counter equals TIMEOUT_CYCLES-1: go to RESP with rsp_err=1 and rsp_data=ERR_DATA.
  - WAIT_RD therefore lasts at most TIMEOUT_CYCLES cycles; a timed-out rsp_vld rises at T+2+TIMEOUT_CYCLES.
  - If rd_vld arrives in that final cycle, the data wins: no error.
- RESP:
  - rsp_vld=1; rsp_rw/rsp_data/rsp_err held stable until rsp_vld && rsp_rdy.
  - That handshake cycle is the last cycle of RESP; next state IDLE.
  - req_rdy=0 in ISSUE, WAIT_RD and RESP. The next request is accepted no earlier than the cycle after the response handshake.
- pio_addr/pio_data_w/pio_rw hold their last driven values outside ISSUE; only pio_cmd_vld qualifies them.

stray_rd:
- Set when pio_rd_vld=1 in any state other than WAIT_RD. This includes a late rd_vld after a timeout.
- Sticky; cleared only by reset. Stray data is discarded.

Width rules:
- Address and data pass through unmodified.
- Timeout counter is 8 bits and saturates; no wrap-around.

Test Plan:
- Write: req(rw=1, addr=16'h0000, wdata=32'hA5A5_0001) at T -> pio_cmd_vld=1 at T+1 only, with addr 0000 and data A5A5_0001; rsp_vld=1 at T+2 with rsp_rw=1, err=0, data=0; req_rdy returns at T+3 when rsp_rdy=1.
- Read, 1-cycle responder model returning 32'h1234_5678 for addr 16'h8003 -> pio_cmd_vld at T+1 with rw=0; rsp_vld at T+3 with rsp_data=1234_5678, rsp_err=0.
- Timeout: read with silent responder, TIMEOUT_CYCLES=16 -> rsp_vld at T+18, rsp_err=1, rsp_data=DEAD_BEEF; rd_vld injected at T+20 -> stray_rd=1, and it stays 1.
- Backpressure: rsp_rdy held low 5 cycles after a read response -> rsp_vld/rsp_data stable, req_rdy=0, no further pio_cmd_vld; rsp_rdy=1 -> back to IDLE next cycle.
- Reset mid-op: reset asserted during WAIT_RD -> next cycle all outputs at reset values and no rsp_vld; a following write completes normally at T+2.
- Boundary: rd_vld arriving in the final WAIT_RD cycle (T+17 with TIMEOUT_CYCLES=16) -> rsp_err=0, captured data returned. Back-to-back requests with rsp_rdy tied high -> commands spaced exactly 3 cycles apart for writes and 4 cycles apart for 1-cycle reads.
